clk_div_cfg_ctrl: RTL and testbench
===================================

# clk_div_cfg_ctrl

Reconfiguration sequencer that sits directly upstream of the integer clock divider. It accepts new divide values from a register interface through a valid/ready handshake and holds the divider's `div_i` in a register. On each change it gates the divided clock, loads the new value, waits for the divider's done indication, and then ungates. No glitch or runt pulse from a divide-value change ever reaches downstream logic.

## Interface
- `DIV_VALUE_WIDTH`, default 32: width of the divide value; divide ratio = value + 1.
- `DIV_RESET_VAL`, default 0: value of `div_o` after reset.
- `GATE_CYCLES`, default 2: settle cycles between deasserting `clk_en_o` and loading the new value; legal range is 1 or more.
- `TIMEOUT_WIDTH`, default 16: width of the wait-for-done timeout counter.
- `clk_i`  in  1  source clock (same clock as the divider).
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `cfg_div_i`  in  DIV_VALUE_WIDTH  requested divide value.
- `cfg_valid_i`  in  1  request valid.
- `cfg_ready_o`  out  1  request accepted when high together with `cfg_valid_i`.
- `busy_o`  out  1  a reconfiguration is in progress.
- `div_o`  out  DIV_VALUE_WIDTH  registered divide value, wired to the divider's `div_i`.
- `div_valid_o`  out  1  load request to the divider.
- `div_ready_i`  in  1  divider ready.
- `div_done_i`  in  1  divider done (new ratio stable).
- `clk_en_o`  out  1  enable for the downstream clock gate on the divided clock.
- `done_o`  out  1  one-cycle pulse when a reconfiguration completes.
- `err_o`  out  1  one-cycle pulse when the done wait times out.

## Operation
- States:
  - IDLE: accepts requests.
  - GATE: clock gated, settling.
  - LOAD: handshake to the divider.
  - WAIT: waiting for `div_done_i`, timeout counter running.
- `cfg_ready_o` = (state == IDLE). `busy_o` = (state != IDLE).
- IDLE, request accepted with `cfg_div_i` != `div_o`:
  - capture `cfg_div_i` into the pending register;
  - clear `clk_en_o`;
  - go to GATE with the gate counter at 0.
- IDLE, request accepted with `cfg_div_i` == `div_o`:
  - stay in IDLE;
  - pulse `done_o` the next cycle;
  - `clk_en_o`, `div_o` and `div_valid_o` are untouched.
- GATE: increment the gate counter. When it reaches GATE_CYCLES-1, load `div_o` with the pending value and go to LOAD.
- LOAD:
  - `div_valid_o` = 1, `div_o` stable.
  - Stay until `div_ready_i` = 1.
  - On handshake, clear the timeout counter and go to WAIT.
- WAIT:
  - `div_done_i` is sampled only in this state; the divider clears done on handshake, so a stale done from the previous value is never sampled.
  - On `div_done_i` = 1: set `clk_en_o`, pulse `done_o`, go to IDLE.
  - Otherwise increment the timeout counter.
  - When the counter equals all-ones and done is still low: set `clk_en_o`, pulse `err_o` (no `done_o`), go to IDLE. `div_o` keeps the new value.
- `cfg_valid_i` while busy: no acceptance. The requester holds the request; it is accepted on the first IDLE cycle.
- `div_o`, `clk_en_o`, `done_o`, `err_o` and `div_valid_o` are all flop outputs; none is combinational from inputs.
- Counter widths: the gate counter is $clog2(GATE_CYCLES)+1 bits; the timeout counter is TIMEOUT_WIDTH bits and saturates at the exit condition, never wraps.

## Timing
- Reset values:
  - state IDLE;
  - `div_o` = DIV_RESET_VAL;
  - `clk_en_o` = 1;
  - `cfg_ready_o` = 1;
  - `busy_o`, `div_valid_o`, `done_o`, `err_o` = 0;
  - all counters 0.
- Request accepted in cycle 0 (value differs):
  - cycles 1..GATE_CYCLES: GATE, `clk_en_o` = 0.
  - cycle GATE_CYCLES+1: LOAD, `div_o` = new value, `div_valid_o` = 1.
  - With `div_ready_i` tied high, the handshake happens in that same cycle and WAIT starts the next cycle.
  - Done sampled high in WAIT cycle N: cycle N+1 has IDLE, `clk_en_o` = 1, `done_o` = 1, `cfg_ready_o` = 1.
- Same-value request accepted in cycle 0: `done_o` = 1 in cycle 1, `cfg_ready_o` stays 1.
- Timeout: `err_o` pulses 2^TIMEOUT_WIDTH cycles after WAIT entry.
- `div_o` never changes while `clk_en_o` = 1.
- Asynchronous reset mid-sequence (any state): all outputs return to reset values immediately, and the pending value is discarded.

## Test plan
- Reset: assert `rst_n_i` for 3 cycles, then release. Check `div_o` = DIV_RESET_VAL, `clk_en_o` = 1, `cfg_ready_o` = 1, all pulses 0.
- Nominal load, with a divider model (ready = 1, done high 7 matches after handshake): request `cfg_div_i` = 3, GATE_CYCLES = 2.
  - `clk_en_o` low in cycles 1–2.
  - `div_o` = 3 and `div_valid_o` = 1 in cycle 3.
  - `done_o` pulses once and `clk_en_o` rises in the same cycle.
- Same value: request 3 again once idle. Check `done_o` next cycle, `clk_en_o` never drops, `div_valid_o` stays 0.
- Backpressure and hold-off:
  - Hold `div_ready_i` low for 5 cycles in LOAD: `div_valid_o` stays high and `div_o` stays stable.
  - Assert `cfg_valid_i` with value 9 throughout: it is accepted only on the first IDLE cycle after `done_o`.
- Timeout: TIMEOUT_WIDTH = 4, `div_done_i` tied 0. Check `err_o` 16 cycles after WAIT entry, no `done_o`, `clk_en_o` = 1, `div_o` holds the new value.
- Reset mid-WAIT: assert `rst_n_i` asynchronously between edges. Check outputs return to reset values immediately, then a fresh request of 5 completes normally.

Source files
------------

// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl
// Reconfiguration sequencer for the integer clock divider. A new divide value
// arrives over a valid/ready handshake. The sequencer then gates the divided
// clock, waits a few settle cycles, and loads the value into the divider. It
// waits for the divider's done indication and finally ungates the clock. This
// keeps any runt or glitch pulse caused by a ratio change away from downstream
// logic.
//
// Ports
//   clk_i        source clock (shared with the divider)
//   rst_n_i      asynchronous active-low reset
//   cfg_div_i    requested divide value (ratio = value + 1)
//   cfg_valid_i  request valid
//   cfg_ready_o  request accepted when high together with cfg_valid_i
//   busy_o       reconfiguration in progress
//   div_o        registered divide value, drives the divider's div_i
//   div_valid_o  load request to the divider
//   div_ready_i  divider ready to take a load
//   div_done_i   divider reports the new ratio is stable
//   clk_en_o     enable for the downstream clock gate
//   done_o       one-cycle pulse when a reconfiguration completes
//   err_o        one-cycle pulse when the wait for done times out
module clk_div_cfg_ctrl #(
    parameter int unsigned                DIV_VALUE_WIDTH = 32,
    parameter logic [DIV_VALUE_WIDTH-1:0] DIV_RESET_VAL   = '0,
    parameter int unsigned                GATE_CYCLES     = 2,
    parameter int unsigned                TIMEOUT_WIDTH   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    output logic                       busy_o,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    input  logic                       div_done_i,
    output logic                       clk_en_o,
    output logic                       done_o,
    output logic                       err_o
);

    localparam int unsigned        GATE_W    = $clog2(GATE_CYCLES) + 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_LOAD,
        S_WAIT
    } state_t;

    state_t                     state_q, state_d;
    logic [DIV_VALUE_WIDTH-1:0] pend_q, pend_d;
    logic [DIV_VALUE_WIDTH-1:0] div_d;
    logic                       div_valid_d, clk_en_d, done_d, err_d;
    logic [GATE_W-1:0]          gate_q, gate_d;
    logic [TIMEOUT_WIDTH-1:0]   to_q, to_d;

    assign cfg_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            div_o       <= DIV_RESET_VAL;
            div_valid_o <= 1'b0;
            clk_en_o    <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            gate_q      <= '0;
            to_q        <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            div_o       <= div_d;
            div_valid_o <= div_valid_d;
            clk_en_o    <= clk_en_d;
            done_o      <= done_d;
            err_o       <= err_d;
            gate_q      <= gate_d;
            to_q        <= to_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        div_d       = div_o;
        div_valid_d = div_valid_o;
        clk_en_d    = clk_en_o;
        done_d      = 1'b0;
        err_d       = 1'b0;
        gate_d      = gate_q;
        to_d        = to_q;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    if (cfg_div_i != div_o) begin
                        pend_d   = cfg_div_i;
                        clk_en_d = 1'b0;
                        gate_d   = '0;
                        state_d  = S_GATE;
                    end else begin
                        // Nothing to change in the divider; acknowledge only.
                        done_d = 1'b0 | 1'b1;
                    end
                end
            end
            S_GATE: begin
                gate_d = gate_q + GATE_W'(1);
                // div_o only changes here, while clk_en_o is already low.
                if (gate_q == GATE_LAST) begin
                    div_d       = pend_q;
                    div_valid_d = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (div_ready_i) begin
                    div_valid_d = 1'b0;
                    to_d        = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // Done takes priority over a timeout in the same cycle. The
                // counter holds at all-ones on the exit cycle, so it never wraps.
                if (div_done_i) begin
                    clk_en_d = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else if (to_q == '1) begin
                    clk_en_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    to_d = to_q + TIMEOUT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
module tb_clk_div_cfg_ctrl;

    localparam logic [31:0] RST_VAL = 32'd1;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] cfg_div_i = '0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic        busy_o;
    logic [31:0] div_o;
    logic        div_valid_o;
    logic        div_ready_i = 1'b1;
    logic        div_done_i = 1'b0;
    logic        clk_en_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    // Divider model: done rises in the 7th cycle after the load handshake and
    // stays high until the next handshake.
    int timer = 0;
    bit armed = 1'b0;
    bit done_en = 1'b1;

    clk_div_cfg_ctrl #(
        .DIV_VALUE_WIDTH(32),
        .DIV_RESET_VAL  (RST_VAL),
        .GATE_CYCLES    (2),
        .TIMEOUT_WIDTH  (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .cfg_div_i  (cfg_div_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .busy_o     (busy_o),
        .div_o      (div_o),
        .div_valid_o(div_valid_o),
        .div_ready_i(div_ready_i),
        .div_done_i (div_done_i),
        .clk_en_o   (clk_en_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        vld;
        logic [31:0] div;
        logic        e_en;
        logic        e_dv;
        logic        e_done;
        logic        e_busy;
        logic [31:0] e_div;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic vld, input logic [31:0] div,
                                input logic en, input logic dv, input logic dn,
                                input logic bz, input logic [31:0] ediv);
        vec_t v;
        v.vld = vld; v.div = div; v.e_en = en; v.e_dv = dv;
        v.e_done = dn; v.e_busy = bz; v.e_div = ediv;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0b exp=%0b @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // Advance one cycle; afterwards we sit 1 time unit past the rising edge.
    task automatic step();
        bit hs;
        hs = div_valid_o && div_ready_i && rst_n_i;
        @(posedge clk_i);
        #1;
        if (!rst_n_i) begin
            armed = 1'b0;
            timer = 0;
        end else if (hs) begin
            armed = 1'b1;
            timer = 6;
        end else if (armed && timer > 0) begin
            timer--;
        end
        div_done_i = done_en && armed && (timer == 0);
    endtask

    task automatic wait_done(input string nm, input int start, input int exp_cyc);
        int n;
        n = start;
        while (done_o !== 1'b1 && n < start + 40) begin
            step();
            n++;
        end
        chk32(nm, 32'(n), 32'(exp_cyc));
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk32({pfx, "_div"}, div_o, RST_VAL);
        chk1({pfx, "_en"}, clk_en_o, 1'b1);
        chk1({pfx, "_rdy"}, cfg_ready_o, 1'b1);
        chk1({pfx, "_busy"}, busy_o, 1'b0);
        chk1({pfx, "_dv"}, div_valid_o, 1'b0);
        chk1({pfx, "_done"}, done_o, 1'b0);
        chk1({pfx, "_err"}, err_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Nominal load of 3, then a same-value request. Row i drives cycle i,
        // expectations are for cycle i+1.
        tbl[0]  = mk(1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, RST_VAL);
        tbl[1]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, RST_VAL);
        tbl[2]  = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd3);
        for (int i = 3; i <= 9; i++)
            tbl[i] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
        tbl[10] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3);
        tbl[11] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);
        tbl[12] = mk(1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3);
        tbl[13] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3);

        // Reset
        step(); step(); step();
        chk_reset_vals("rst_held");
        rst_n_i = 1'b1;
        chk_reset_vals("rst_rel");

        for (int i = 0; i < 14; i++) begin
            cfg_valid_i = tbl[i].vld;
            cfg_div_i   = tbl[i].div;
            step();
            chk1($sformatf("tbl%0d_en", i), clk_en_o, tbl[i].e_en);
            chk1($sformatf("tbl%0d_dv", i), div_valid_o, tbl[i].e_dv);
            chk1($sformatf("tbl%0d_done", i), done_o, tbl[i].e_done);
            chk1($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
            chk1($sformatf("tbl%0d_rdy", i), cfg_ready_o, ~tbl[i].e_busy);
            chk1($sformatf("tbl%0d_err", i), err_o, 1'b0);
            chk32($sformatf("tbl%0d_div", i), div_o, tbl[i].e_div);
        end

        // Backpressure in LOAD with a held request of 9
        cfg_valid_i = 1'b1; cfg_div_i = 32'd7; div_ready_i = 1'b0;
        step();
        chk1("bp_c1_busy", busy_o, 1'b1);
        chk1("bp_c1_en", clk_en_o, 1'b0);
        cfg_div_i = 32'd9;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            chk1("bp_load_dv", div_valid_o, 1'b1);
            chk32("bp_load_div", div_o, 32'd7);
            chk1("bp_load_rdy", cfg_ready_o, 1'b0);
            step();
        end
        div_ready_i = 1'b1;
        chk1("bp_c8_dv", div_valid_o, 1'b1);
        chk32("bp_c8_div", div_o, 32'd7);
        step();
        wait_done("bp_done_cyc", 9, 16);
        chk1("bp_done_rdy", cfg_ready_o, 1'b1);
        chk1("bp_done_en", clk_en_o, 1'b1);
        step();
        chk1("bp_acc9_busy", busy_o, 1'b1);
        chk1("bp_acc9_done", done_o, 1'b0);
        chk1("bp_acc9_en", clk_en_o, 1'b0);
        cfg_valid_i = 1'b0;
        step(); step();
        chk32("bp9_div", div_o, 32'd9);
        chk1("bp9_dv", div_valid_o, 1'b1);
        wait_done("bp9_done_cyc", 19, 27);

        // Timeout with done held low
        done_en = 1'b0; div_done_i = 1'b0;
        step();
        cfg_valid_i = 1'b1; cfg_div_i = 32'd4;
        step();
        cfg_valid_i = 1'b0;
        step(); step();
        chk32("to_load_div", div_o, 32'd4);
        chk1("to_load_dv", div_valid_o, 1'b1);
        step();
        for (int c = 4; c < 20; c++) begin
            chk1("to_wait_err", err_o, 1'b0);
            chk1("to_wait_en", clk_en_o, 1'b0);
            chk1("to_wait_busy", busy_o, 1'b1);
            step();
        end
        chk1("to_err", err_o, 1'b1);
        chk1("to_no_done", done_o, 1'b0);
        chk1("to_en", clk_en_o, 1'b1);
        chk1("to_busy", busy_o, 1'b0);
        chk32("to_div", div_o, 32'd4);
        step();
        chk1("to_err_pulse", err_o, 1'b0);

        // Asynchronous reset in WAIT, then a fresh request
        done_en = 1'b1;
        cfg_valid_i = 1'b1; cfg_div_i = 32'd6;
        step();
        cfg_valid_i = 1'b0;
        step(); step(); step(); step();
        chk1("mr_pre_busy", busy_o, 1'b1);
        #3;
        rst_n_i = 1'b0;
        #1;
        chk_reset_vals("mr_async");
        step(); step();
        rst_n_i = 1'b1;
        cfg_valid_i = 1'b1; cfg_div_i = 32'd5;
        step();
        cfg_valid_i = 1'b0;
        chk1("mr_c1_en", clk_en_o, 1'b0);
        step(); step();
        chk32("mr_c3_div", div_o, 32'd5);
        chk1("mr_c3_dv", div_valid_o, 1'b1);
        wait_done("mr_done_cyc", 3, 11);
        chk1("mr_done_en", clk_en_o, 1'b1);
        chk32("mr_done_div", div_o, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
